// File: rtl/brcmp_pkg.sv
// brcmp_pkg: shared definitions for the iterative branch comparator.
//   XLEN      - operand width (only 32 is supported)
//   CHUNK     - bits compared per iterative step
//   STEPS     - number of chunk steps per operand
//   MSB_IDX   - step index of the most significant chunk
//   state_t   - FSM encoding (IDLE / CMP / DONE)
package brcmp_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned STEPS = XLEN / CHUNK;

    localparam logic [1:0] MSB_IDX = 2'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/brcmp_chunk.sv
// brcmp_chunk: combinational compare of one CHUNK-wide slice.
//   a, b      - chunk operands
//   is_signed - 1: treat a/b as two's-complement, 0: unsigned
//   eq/gt/lt  - a == b, a > b, a < b under the chosen signedness
module brcmp_chunk
    import brcmp_pkg::*;
(
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_signed,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    always_comb begin
        eq = (a == b);
        if (is_signed) begin
            gt = ($signed(a) > $signed(b));
            lt = ($signed(a) < $signed(b));
        end else begin
            gt = (a > b);
            lt = (a < b);
        end
    end

endmodule

// File: rtl/branch_compare.sv
// branch_compare: multi-cycle signed/unsigned operand comparator for branches.
// Operands are latched on start and compared one CHUNK at a time from the MSB
// chunk down, exiting early on the first differing chunk.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - compare request, accepted only while ready
//   flush               - abort an in-flight compare (no done, flags kept)
//   rs1, rs2            - operands
//   is_unsigned         - 1: unsigned compare, 0: signed compare
//   ready               - idle, start will be accepted
//   done                - one-cycle pulse: flags hold a fresh result
//   equal/greater/less  - result flags, held until the next result
// Build option: define BRCMP_SINGLE_CYCLE_EN to compare the full width in
// the accepting cycle (CMP is skipped, latency is always one cycle).
module branch_compare #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            is_unsigned,
    output logic            ready,
    output logic            done,
    output logic            equal,
    output logic            greater,
    output logic            less
);

    import brcmp_pkg::*;

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic              r_unsigned;
    logic              r_equal;
    logic              r_greater;
    logic              r_less;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic              w_chunk_signed;
    logic              w_eq;
    logic              w_gt;
    logic              w_lt;

    always_comb begin
        w_a_chunk = r_rs1[0 +: CHUNK];
        w_b_chunk = r_rs2[0 +: CHUNK];
        case (r_idx)
            2'd3: begin
                w_a_chunk = r_rs1[3*CHUNK +: CHUNK];
                w_b_chunk = r_rs2[3*CHUNK +: CHUNK];
            end
            2'd2: begin
                w_a_chunk = r_rs1[2*CHUNK +: CHUNK];
                w_b_chunk = r_rs2[2*CHUNK +: CHUNK];
            end
            2'd1: begin
                w_a_chunk = r_rs1[1*CHUNK +: CHUNK];
                w_b_chunk = r_rs2[1*CHUNK +: CHUNK];
            end
            default: ;
        endcase
    end

    // Only the MSB chunk carries the sign; lower chunks are magnitude bits.
    assign w_chunk_signed = (r_idx == MSB_IDX) && !r_unsigned;

    brcmp_chunk u_chunk (
        .a         (w_a_chunk),
        .b         (w_b_chunk),
        .is_signed (w_chunk_signed),
        .eq        (w_eq),
        .gt        (w_gt),
        .lt        (w_lt)
    );

`ifdef BRCMP_SINGLE_CYCLE_EN
    logic w_full_gt;
    logic w_full_lt;

    always_comb begin
        if (is_unsigned) begin
            w_full_gt = (rs1 > rs2);
            w_full_lt = (rs1 < rs2);
        end else begin
            w_full_gt = ($signed(rs1) > $signed(rs2));
            w_full_lt = ($signed(rs1) < $signed(rs2));
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= 2'd0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_unsigned <= 1'b0;
            r_equal    <= 1'b0;
            r_greater  <= 1'b0;
            r_less     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rs1      <= rs1;
                        r_rs2      <= rs2;
                        r_unsigned <= is_unsigned;
`ifdef BRCMP_SINGLE_CYCLE_EN
                        r_equal    <= (rs1 == rs2);
                        r_greater  <= w_full_gt;
                        r_less     <= w_full_lt;
                        r_state    <= DONE;
`else
                        r_idx      <= MSB_IDX;
                        r_state    <= CMP;
`endif
                    end
                end
                CMP: begin
                    // Flush wins over any chunk result; flags stay untouched.
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (!w_eq) begin
                        r_equal   <= 1'b0;
                        r_greater <= w_gt;
                        r_less    <= w_lt;
                        r_state   <= DONE;
                    end else if (r_idx == 2'd0) begin
                        r_equal   <= 1'b1;
                        r_greater <= 1'b0;
                        r_less    <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_idx <= r_idx - 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready   = (r_state == IDLE);
    assign done    = (r_state == DONE);
    assign equal   = r_equal;
    assign greater = r_greater;
    assign less    = r_less;

endmodule

// File: doc/branch_compare.md
BRANCH_COMPARE -- requirements
Module: branch_compare

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand width; only 32 is supported.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits compared per iterative cycle; XLEN/CHUNK = 4 steps.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to compare; accepted only while ready=1.
REQ-006 SHALL have port flush  input  1  abort of an in-flight compare.
REQ-007 SHALL have port rs1  input  XLEN  first operand.
REQ-008 SHALL have port rs2  input  XLEN  second operand.
REQ-009 SHALL have port is_unsigned  input  1  1 = unsigned compare; 0 = signed two's-complement compare (branch funct3[1]).
REQ-010 SHALL have port ready  output  1  block idle and able to accept start.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the flags hold a new result.
REQ-012 SHALL have port equal  output  1  rs1 == rs2.
REQ-013 SHALL have port greater  output  1  rs1 > rs2 under the selected signedness.
REQ-014 SHALL have port less  output  1  rs1 < rs2 under the selected signedness.

Function
REQ-015 SHALL implement FSM states IDLE, CMP, DONE; ready = (state == IDLE); done = (state == DONE).
REQ-016 In IDLE with start=1, SHALL latch rs1, rs2 and is_unsigned, set the step index to 3 (MSB chunk), and enter CMP.
REQ-017 In IDLE with start=0, SHALL remain in IDLE.
REQ-018 In CMP, SHALL compare chunk [idx*8+7 : idx*8] of the latched operands.
- idx = 3 uses the selected signedness.
- Lower chunks are compared unsigned.
REQ-019 On a chunk mismatch, SHALL load greater/less, clear equal, and enter DONE (early exit).
REQ-020 On a chunk match with idx = 0, SHALL set equal, clear greater/less, and enter DONE.
REQ-021 On a chunk match with idx > 0, SHALL decrement idx and stay in CMP.
REQ-022 Latency from the accepting edge to done high SHALL be 2 cycles for an MSB-chunk mismatch and 5 cycles for fully equal operands; general case = 2 + (3 − idx of first mismatching chunk).
REQ-023 DONE SHALL last exactly one cycle and then return to IDLE; start during DONE SHALL be ignored.
REQ-024 Flags SHALL hold their last value until the next transition into DONE.
- After any completed compare, exactly one of equal/greater/less is 1.
REQ-025 start while not IDLE SHALL be ignored.
REQ-026 Operand or is_unsigned changes after acceptance SHALL have no effect.
REQ-027 flush=1 in CMP SHALL force IDLE on the next edge, with no done pulse and flags unchanged.
REQ-028 flush has priority over chunk results; flush in IDLE or DONE SHALL have no effect, and done still pulses in DONE.
REQ-029 flush and start together in IDLE SHALL accept the start.

Reset
REQ-030 While rst_n=0, SHALL force state IDLE and idx 0, clear equal, greater and less, and latched operands to 0; hence ready=1 and done=0.
REQ-031 Reset asserted mid-compare SHALL abort it immediately, with no done pulse after release.

Configuration
REQ-032 Macro BRCMP_SINGLE_CYCLE_EN defined: SHALL skip CMP. A start accepted in IDLE compares the full XLEN operands in one step, loads the flags and enters DONE, giving a latency of 1 cycle always; flush has no effect.
REQ-033 Macro BRCMP_SINGLE_CYCLE_EN undefined: SHALL use the iterative CMP behaviour of REQ-018..REQ-022; port list is identical in both builds.

Structure
REQ-034 Shared package brcmp_pkg SHALL hold the state enum (IDLE/CMP/DONE), XLEN, CHUNK and the step count constant.
REQ-035 SHALL instantiate one combinational sub-module brcmp_chunk.
- Inputs: a[7:0], b[7:0], is_signed.
- Outputs: eq, gt, lt.
- Used for the current chunk; the single-cycle build may use a direct full-width compare instead.

Verification
REQ-036 Signed MSB mismatch: rs1=0xFFFFFFFF, rs2=0x00000001, is_unsigned=0 -> done 2 cycles after accept; less=1, greater=0, equal=0.
REQ-037 Unsigned, same operands: rs1=0xFFFFFFFF, rs2=0x00000001, is_unsigned=1 -> done 2 cycles after accept; greater=1.
REQ-038 Full-length equal: rs1=rs2=0x12345678 -> done 5 cycles after accept; equal=1; a start pulse during CMP is ignored.
REQ-039 LSB-only difference: rs1=0x00000010, rs2=0x00000020, signed -> done 5 cycles after accept; less=1.
REQ-040 Flush mid-compare: rs1=rs2=0xA5A5A5A5, flush 2 cycles after accept -> ready=1 next cycle, no done, flags keep prior values.
REQ-041 Reset mid-compare: rst_n=0 during CMP -> ready=1, all flags 0 immediately; no done after release; a new compare then completes normally.
